// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer and the LED driver top.
package led_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } led_state_e;

    // 1 s at 50 MHz
    localparam int DEF_TICK_DIV     = 50000000;
    localparam int DEF_SEL_W        = 2;
    localparam int DEF_TOGGLES      = 4;
    localparam int DEF_NUM_LEDS     = 3;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the button logic, the sequencer and the LED driver.
//
// Signalling: there is no valid/ready pairing on this bundle. start and stop
// are single-cycle request pulses sampled on every rising clk edge and are
// always accepted (stop wins when both are high). delay_1s, led_load_en and
// done are single-cycle pulses the receiver must consume in the cycle they
// are high; led_sel, busy and state are levels.
interface led_seq_ctrl_if #(
    parameter int SEL_W = led_pkg::DEF_SEL_W
);
    import led_pkg::*;

    logic             start;
    logic             stop;
    logic             loop_en;
    logic             delay_1s;
    logic             led_load_en;
    logic [SEL_W-1:0] led_sel;
    logic             busy;
    logic             done;
    led_state_e       state;       // sequencer state, for observation

    // Button / top side
    modport master (
        output start, stop, loop_en,
        input  delay_1s, led_load_en, led_sel, busy, done, state
    );

    // Sequencer side
    modport slave (
        input  start, stop, loop_en,
        output delay_1s, led_load_en, led_sel, busy, done, state
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler with count enable and synchronous clear; pulses tick while
// enabled in the terminal-count cycle.
module tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int           CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise count and wrap at terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: walks led_sel across the LEDs, giving each a fixed number
// of 1 s toggle strobes, with single-pass or looping runs and pause/resume.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int TOGGLES_PER_LED = DEF_TOGGLES,
    parameter int NUM_LEDS        = DEF_NUM_LEDS,
    parameter int SEL_W           = DEF_SEL_W
) (
    input  logic          clk,
    input  logic          rst,
    led_seq_ctrl_if.slave bus
);

    localparam int              TOG_W    = $clog2(TOGGLES_PER_LED) + 1;
    localparam logic [TOG_W-1:0] TOG_MAX  = TOG_W'(TOGGLES_PER_LED - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_LEDS - 1);

    led_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic             done_q, done_d;
    logic             strobe;

    // Prescaler runs only in RUN and restarts from zero on every LOAD
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .clr  (state_q == ST_LOAD),
        .tick (strobe)
    );

    // Next state, toggle counter, LED index and done pulse
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tog_d   = tog_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sel_d   = '0;
                tog_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (strobe) begin
                    if (tog_q == TOG_MAX) begin
                        tog_d = '0;
                        if (sel_q == SEL_LAST) begin
                            sel_d = '0;
                            if (!bus.loop_en) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end else begin
                        tog_d = tog_q + TOG_W'(1);
                    end
                end
                // A completed single pass ends in IDLE even if stop arrives on
                // that same strobe; otherwise stop parks the run in PAUSE.
                if (bus.stop && state_d == ST_RUN) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.start && !bus.stop) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            tog_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tog_q   <= tog_d;
            done_q  <= done_d;
        end
    end

    assign bus.delay_1s    = strobe;
    assign bus.led_load_en = (state_q == ST_LOAD);
    assign bus.led_sel     = sel_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed test-plan scenarios plus random
// start/stop/loop/reset traffic, all checked every cycle against a
// reference model built from elapsed run time and strobe counts.
module tb_led_seq_ctrl;
  import led_pkg::*;

  localparam int TD  = 4;
  localparam int TPL = 2;
  localparam int NL  = 3;
  localparam int SW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_seq_ctrl_if #(.SEL_W(SW)) bus_if ();

  led_seq_ctrl #(
    .TICK_DIV        (TD),
    .TOGGLES_PER_LED (TPL),
    .NUM_LEDS        (NL),
    .SEL_W           (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0       = 0;
  int str_q[$];
  int done_q[$];
  int load_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_el: RUN cycles modulo the strobe period; m_n: strobes in current pass.
  led_state_e m_state;
  int         m_el;
  int         m_n;
  logic       m_done;

  function automatic int exp_sel();
    if (m_state == ST_RUN || m_state == ST_PAUSE) return (m_n / TPL) % NL;
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic s, input logic p, input logic l);
    if (r) begin
      m_state = ST_IDLE;
      m_el    = 0;
      m_n     = 0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_state)
        ST_IDLE:  if (s && !p) m_state = ST_LOAD;
        ST_LOAD: begin
          m_el    = 0;
          m_n     = 0;
          m_state = ST_RUN;
        end
        ST_RUN: begin
          if (m_el == TD - 1) begin
            m_n++;
            if (m_n == TPL * NL) begin
              m_n = 0;
              if (!l) begin
                m_state = ST_IDLE;
                m_done  = 1'b1;
              end
            end
          end
          m_el = (m_el + 1) % TD;
          if (m_state == ST_RUN && p) m_state = ST_PAUSE;
        end
        ST_PAUSE: if (s && !p) m_state = ST_RUN;
        default:  m_state = ST_IDLE;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check outputs of this cycle, apply this cycle's inputs.
  task automatic cycle(input logic r, input logic s, input logic p, input logic l);
    @(negedge clk);
    check("delay_1s",    32'(bus_if.delay_1s),    32'(m_state == ST_RUN && m_el == TD - 1));
    check("led_load_en", 32'(bus_if.led_load_en), 32'(m_state == ST_LOAD));
    check("busy",        32'(bus_if.busy),        32'(m_state != ST_IDLE));
    check("done",        32'(bus_if.done),        32'(m_done));
    check("led_sel",     32'(bus_if.led_sel),     32'(exp_sel()));
    check("state",       32'(bus_if.state),       32'(m_state));
    if (bus_if.delay_1s)    str_q.push_back(cyc - t0);
    if (bus_if.done)        done_q.push_back(cyc - t0);
    if (bus_if.led_load_en) load_q.push_back(cyc - t0);
    rst            = r;
    bus_if.start   = s;
    bus_if.stop    = p;
    bus_if.loop_en = l;
    model_update(r, s, p, l);
    cyc++;
  endtask

  task automatic clear_logs();
    str_q.delete();
    done_q.delete();
    load_q.delete();
    t0 = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_str[6];
    logic lp;
    exp_str = '{5, 9, 13, 17, 21, 25};

    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.stop = 1'b0;
    bus_if.loop_en = 1'b0;
    m_state = ST_IDLE;
    m_el = 0;
    m_n = 0;
    m_done = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with start asserted: nothing may start
    clear_logs();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("rst_no_load", 32'(load_q.size()), 0);

    // Single pass
    clear_logs();
    cycle(0, 1, 0, 0);
    repeat (29) cycle(0, 0, 0, 0);
    check("sp_nstrobe", 32'(str_q.size()), 6);
    for (int i = 0; i < 6 && i < str_q.size(); i++) check("sp_strobe_cyc", 32'(str_q[i]), 32'(exp_str[i]));
    check("sp_ndone", 32'(done_q.size()), 1);
    if (done_q.size() > 0) check("sp_done_cyc", 32'(done_q[0]), 26);
    check("sp_nload", 32'(load_q.size()), 1);
    if (load_q.size() > 0) check("sp_load_cyc", 32'(load_q[0]), 1);

    // Looping
    clear_logs();
    cycle(0, 1, 0, 1);
    repeat (40) cycle(0, 0, 0, 1);
    check("loop_nstrobe_ge8", 32'(str_q.size() >= 8), 1);
    if (str_q.size() >= 8) begin
      check("loop_strobe7", 32'(str_q[6]), 29);
      check("loop_strobe8", 32'(str_q[7]), 33);
    end
    check("loop_ndone", 32'(done_q.size()), 0);
    check("loop_nload", 32'(load_q.size()), 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Pause at 7, resume at 20
    clear_logs();
    cycle(0, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    repeat (12) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    check("pause_nstrobe_ge2", 32'(str_q.size() >= 2), 1);
    if (str_q.size() >= 2) begin
      check("pause_strobe1", 32'(str_q[0]), 5);
      check("pause_strobe2", 32'(str_q[1]), 22);
    end
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // start+stop together while running -> PAUSE
    clear_logs();
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    @(negedge clk);
    check("collide_pause", 32'(bus_if.state), 32'(ST_PAUSE));
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // stop on the first strobe cycle
    clear_logs();
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    @(negedge clk);
    check("stopstrobe_tog", 32'(dut.tog_q), 1);
    check("stopstrobe_seen", 32'(str_q.size()), 1);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Reset mid-run at 15
    clear_logs();
    cycle(0, 1, 0, 0);
    repeat (14) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0);
    check("midrst_nstrobe", 32'(str_q.size()), 3);
    check("midrst_ndone", 32'(done_q.size()), 0);

    // Random traffic
    lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) lp = ~lp;
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 24) == 0), lp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
